// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register.
// Detects load-use hazards and inserts a bubble for them. Inserts a bubble on a branch/jump
// flush. Writeback data is written through to the captured rs/rt operands. Saturating counters
// record how many stall and flush bubbles have been inserted.
module idex_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               IDvalid,
    input  logic [4:0]         IDrs,
    input  logic [4:0]         IDrt,
    input  logic               IDusesrt,
    input  logic [4:0]         IDrd,
    input  logic [DATA_W-1:0]  IDrsdata,
    input  logic [DATA_W-1:0]  IDrtdata,
    input  logic [DATA_W-1:0]  IDimm,
    input  logic               IDregwrite,
    input  logic               IDmemread,
    input  logic               IDmemwrite,
    input  logic               IDmemtoreg,
    input  logic               IDalusrc,
    input  logic [ALUOP_W-1:0] IDaluop,
    input  logic               WBregwrite,
    input  logic [4:0]         WBrd,
    input  logic [DATA_W-1:0]  WBdata,
    input  logic [1:0]         NPCOp,
    input  logic               memstall,
    output logic               IDEXvalid,
    output logic [4:0]         IDEXrs,
    output logic [4:0]         IDEXrt,
    output logic [4:0]         IDEXrd,
    output logic [DATA_W-1:0]  IDEXrsdata,
    output logic [DATA_W-1:0]  IDEXrtdata,
    output logic [DATA_W-1:0]  IDEXimm,
    output logic               IDEXregwrite,
    output logic               IDEXmemread,
    output logic               IDEXmemwrite,
    output logic               IDEXmemtoreg,
    output logic               IDEXalusrc,
    output logic [ALUOP_W-1:0] IDEXaluop,
    output logic               stall,
    output logic [CNT_W-1:0]   stallcnt,
    output logic [CNT_W-1:0]   flushcnt
);

    logic               valid_q,    valid_d;
    logic [4:0]         rs_q,       rs_d;
    logic [4:0]         rt_q,       rt_d;
    logic [4:0]         rd_q,       rd_d;
    logic [DATA_W-1:0]  rsdata_q,   rsdata_d;
    logic [DATA_W-1:0]  rtdata_q,   rtdata_d;
    logic [DATA_W-1:0]  imm_q,      imm_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q,  memread_d;
    logic               memwrite_q, memwrite_d;
    logic               memtoreg_q, memtoreg_d;
    logic               alusrc_q,   alusrc_d;
    logic [ALUOP_W-1:0] aluop_q,    aluop_d;
    logic [CNT_W-1:0]   stallcnt_q, stallcnt_d;
    logic [CNT_W-1:0]   flushcnt_q, flushcnt_d;

    logic               flush;
    logic               haz;
    logic [DATA_W-1:0]  rs_wt;
    logic [DATA_W-1:0]  rt_wt;

    // Load-use hazard detection, flush decode and writeback write-through operand selection
    always_comb begin
        flush = (NPCOp != 2'b00);
        haz   = valid_q & memread_q & (rd_q != 5'd0) & IDvalid &
                ((rd_q == IDrs) | (IDusesrt & (rd_q == IDrt)));
        stall = haz & ~flush & ~memstall;
        rs_wt = (WBregwrite && (WBrd != 5'd0) && (WBrd == IDrs)) ? WBdata : IDrsdata;
        rt_wt = (WBregwrite && (WBrd != 5'd0) && (WBrd == IDrt)) ? WBdata : IDrtdata;
    end

    // Next-state selection: freeze > flush bubble > load-use bubble > capture
    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rsdata_d   = rsdata_q;
        rtdata_d   = rtdata_q;
        imm_d      = imm_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        memtoreg_d = memtoreg_q;
        alusrc_d   = alusrc_q;
        aluop_d    = aluop_q;
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        if (!memstall) begin
            if (flush || haz) begin
                valid_d    = 1'b0;
                rs_d       = '0;
                rt_d       = '0;
                rd_d       = '0;
                rsdata_d   = '0;
                rtdata_d   = '0;
                imm_d      = '0;
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                memtoreg_d = 1'b0;
                alusrc_d   = 1'b0;
                aluop_d    = '0;
                // flush takes precedence, so a simultaneous hazard is not counted as a stall
                if (flush) begin
                    if (flushcnt_q != '1) flushcnt_d = flushcnt_q + 1'b1;
                end else begin
                    if (stallcnt_q != '1) stallcnt_d = stallcnt_q + 1'b1;
                end
            end else begin
                valid_d    = IDvalid;
                rs_d       = IDrs;
                rt_d       = IDrt;
                rd_d       = IDrd;
                rsdata_d   = rs_wt;
                rtdata_d   = rt_wt;
                imm_d      = IDimm;
                regwrite_d = IDvalid & IDregwrite;
                memread_d  = IDvalid & IDmemread;
                memwrite_d = IDvalid & IDmemwrite;
                memtoreg_d = IDvalid & IDmemtoreg;
                alusrc_d   = IDvalid & IDalusrc;
                aluop_d    = IDaluop;
            end
        end
    end

    // Pipeline register and counters with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rsdata_q   <= '0;
            rtdata_q   <= '0;
            imm_q      <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            alusrc_q   <= 1'b0;
            aluop_q    <= '0;
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rsdata_q   <= rsdata_d;
            rtdata_q   <= rtdata_d;
            imm_q      <= imm_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            alusrc_q   <= alusrc_d;
            aluop_q    <= aluop_d;
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign IDEXvalid    = valid_q;
    assign IDEXrs       = rs_q;
    assign IDEXrt       = rt_q;
    assign IDEXrd       = rd_q;
    assign IDEXrsdata   = rsdata_q;
    assign IDEXrtdata   = rtdata_q;
    assign IDEXimm      = imm_q;
    assign IDEXregwrite = regwrite_q;
    assign IDEXmemread  = memread_q;
    assign IDEXmemwrite = memwrite_q;
    assign IDEXmemtoreg = memtoreg_q;
    assign IDEXalusrc   = alusrc_q;
    assign IDEXaluop    = aluop_q;
    assign stallcnt     = stallcnt_q;
    assign flushcnt     = flushcnt_q;

endmodule

// File: tb/tb_idex_stage_reg.sv
// Bench for idex_stage_reg: a cycle-by-cycle vector table checked through a scoreboard queue,
// then hand-written sequences for freeze, rt write-through, reset during a stall and
// counter saturation (counters narrowed to 4 bits so saturation is reachable quickly).
module tb_idex_stage_reg;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        IDvalid, IDusesrt;
    logic [4:0]  IDrs, IDrt, IDrd;
    logic [31:0] IDrsdata, IDrtdata, IDimm;
    logic        IDregwrite, IDmemread, IDmemwrite, IDmemtoreg, IDalusrc;
    logic [3:0]  IDaluop;
    logic        WBregwrite;
    logic [4:0]  WBrd;
    logic [31:0] WBdata;
    logic [1:0]  NPCOp;
    logic        memstall;
    logic        IDEXvalid;
    logic [4:0]  IDEXrs, IDEXrt, IDEXrd;
    logic [31:0] IDEXrsdata, IDEXrtdata, IDEXimm;
    logic        IDEXregwrite, IDEXmemread, IDEXmemwrite, IDEXmemtoreg, IDEXalusrc;
    logic [3:0]  IDEXaluop;
    logic        stall;
    logic [CW-1:0] stallcnt, flushcnt;

    int n_checks = 0;
    int n_fail   = 0;

    idex_stage_reg #(.DATA_W(32), .ALUOP_W(4), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn), .IDvalid(IDvalid), .IDrs(IDrs), .IDrt(IDrt),
        .IDusesrt(IDusesrt), .IDrd(IDrd), .IDrsdata(IDrsdata), .IDrtdata(IDrtdata),
        .IDimm(IDimm), .IDregwrite(IDregwrite), .IDmemread(IDmemread),
        .IDmemwrite(IDmemwrite), .IDmemtoreg(IDmemtoreg), .IDalusrc(IDalusrc),
        .IDaluop(IDaluop), .WBregwrite(WBregwrite), .WBrd(WBrd), .WBdata(WBdata),
        .NPCOp(NPCOp), .memstall(memstall), .IDEXvalid(IDEXvalid), .IDEXrs(IDEXrs),
        .IDEXrt(IDEXrt), .IDEXrd(IDEXrd), .IDEXrsdata(IDEXrsdata), .IDEXrtdata(IDEXrtdata),
        .IDEXimm(IDEXimm), .IDEXregwrite(IDEXregwrite), .IDEXmemread(IDEXmemread),
        .IDEXmemwrite(IDEXmemwrite), .IDEXmemtoreg(IDEXmemtoreg), .IDEXalusrc(IDEXalusrc),
        .IDEXaluop(IDEXaluop), .stall(stall), .stallcnt(stallcnt), .flushcnt(flushcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rstn, idv;
        logic [4:0]  rs, rt, rd;
        logic        usesrt;
        logic [31:0] rsdata;
        logic        rw, mr;
        logic [3:0]  alu;
        logic        wbwe;
        logic [4:0]  wbrd;
        logic [31:0] wbdata;
        logic [1:0]  npc;
        logic        ms;
        logic        chks, es, ev;
        logic [4:0]  ers, erd;
        logic [31:0] ersdata;
        logic        erw, emr;
        logic [3:0]  ealu;
        logic [CW-1:0] escnt, efcnt;
    } vec_t;

    vec_t tbl[16];
    vec_t sb[$];

    function automatic vec_t v(
        input logic rstn_, idv, input logic [4:0] rs, rt, rd, input logic usesrt,
        input logic [31:0] rsdata, input logic rw, mr, input logic [3:0] alu,
        input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbdata,
        input logic [1:0] npc, input logic ms,
        input logic chks, es, ev, input logic [4:0] ers, erd, input logic [31:0] ersdata,
        input logic erw, emr, input logic [3:0] ealu, input logic [CW-1:0] escnt, efcnt);
        vec_t r;
        r.rstn = rstn_; r.idv = idv; r.rs = rs; r.rt = rt; r.rd = rd; r.usesrt = usesrt;
        r.rsdata = rsdata; r.rw = rw; r.mr = mr; r.alu = alu; r.wbwe = wbwe; r.wbrd = wbrd;
        r.wbdata = wbdata; r.npc = npc; r.ms = ms; r.chks = chks; r.es = es; r.ev = ev;
        r.ers = ers; r.erd = erd; r.ersdata = ersdata; r.erw = erw; r.emr = emr;
        r.ealu = ealu; r.escnt = escnt; r.efcnt = efcnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_id(input logic idv, input logic [4:0] rs, rt, rd, input logic usesrt,
                          input logic [31:0] rsdata, rtdata, imm,
                          input logic rw, mr, mw, mtr, asrc, input logic [3:0] alu);
        IDvalid = idv; IDrs = rs; IDrt = rt; IDrd = rd; IDusesrt = usesrt;
        IDrsdata = rsdata; IDrtdata = rtdata; IDimm = imm;
        IDregwrite = rw; IDmemread = mr; IDmemwrite = mw; IDmemtoreg = mtr; IDalusrc = asrc;
        IDaluop = alu;
    endtask

    task automatic set_misc(input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbdata,
                            input logic [1:0] npc, input logic ms);
        WBregwrite = wbwe; WBrd = wbrd; WBdata = wbdata; NPCOp = npc; memstall = ms;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // drive a table row, check combinational stall, queue the registered expectation,
    // then compare after the edge
    task automatic apply(input int idx, input vec_t x);
        vec_t e;
        rstn = x.rstn;
        set_id(x.idv, x.rs, x.rt, x.rd, x.usesrt, x.rsdata, 32'h0, 32'h0, x.rw, x.mr,
               1'b0, 1'b0, 1'b0, x.alu);
        set_misc(x.wbwe, x.wbrd, x.wbdata, x.npc, x.ms);
        #1;
        if (x.chks) chk($sformatf("row%0d stall", idx), {31'd0, stall}, {31'd0, x.es});
        sb.push_back(x);
        tick();
        e = sb.pop_front();
        chk($sformatf("row%0d valid", idx),    {31'd0, IDEXvalid},    {31'd0, e.ev});
        chk($sformatf("row%0d rs", idx),       {27'd0, IDEXrs},       {27'd0, e.ers});
        chk($sformatf("row%0d rd", idx),       {27'd0, IDEXrd},       {27'd0, e.erd});
        chk($sformatf("row%0d rsdata", idx),   IDEXrsdata,            e.ersdata);
        chk($sformatf("row%0d regwrite", idx), {31'd0, IDEXregwrite}, {31'd0, e.erw});
        chk($sformatf("row%0d memread", idx),  {31'd0, IDEXmemread},  {31'd0, e.emr});
        chk($sformatf("row%0d aluop", idx),    {28'd0, IDEXaluop},    {28'd0, e.ealu});
        chk($sformatf("row%0d stallcnt", idx), {28'd0, stallcnt},     {28'd0, e.escnt});
        chk($sformatf("row%0d flushcnt", idx), {28'd0, flushcnt},     {28'd0, e.efcnt});
    endtask

    task automatic drive_lw;
        set_id(1'b1, 5'd1, 5'd5, 5'd5, 1'b0, 32'd100, 32'd200, 32'h10,
               1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
    endtask

    task automatic drive_add_rs5;
        set_id(1'b1, 5'd5, 5'd2, 5'd8, 1'b1, 32'd55, 32'd66, 32'h0,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
    endtask

    initial begin
        //        rstn idv rs rt rd us rsdata       rw mr alu wb wbrd wbdata        npc   ms  chk es ev ers erd ersdata      erw emr ealu sc fc
        tbl[0]  = v(0, 1, 3, 4, 5, 1, 32'hDEAD,    1, 1, 7,  1, 3,  32'h5555,     2'b01, 0,  1, 0, 0, 0, 0, 32'h0,     0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 5, 5, 5, 1, 32'hBEEF,    1, 1, 9,  0, 0,  32'h0,        2'b00, 1,  1, 0, 0, 0, 0, 32'h0,     0, 0, 0, 0, 0);
        tbl[2]  = v(1, 1, 3, 4, 6, 1, 32'h1234,    1, 0, 2,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 3, 6, 32'h1234,  1, 0, 2, 0, 0);
        tbl[3]  = v(1, 1, 1, 5, 5, 0, 32'd100,     1, 1, 0,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 1, 5, 32'd100,   1, 1, 0, 0, 0);
        tbl[4]  = v(1, 1, 5, 2, 8, 1, 32'd55,      1, 0, 3,  0, 0,  32'h0,        2'b00, 0,  1, 1, 0, 0, 0, 32'h0,     0, 0, 0, 1, 0);
        tbl[5]  = v(1, 1, 5, 2, 8, 1, 32'd55,      1, 0, 3,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 5, 8, 32'd55,    1, 0, 3, 1, 0);
        tbl[6]  = v(1, 1, 1, 5, 5, 0, 32'd100,     1, 1, 0,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 1, 5, 32'd100,   1, 1, 0, 1, 0);
        tbl[7]  = v(1, 1, 2, 5, 5, 0, 32'd77,      1, 0, 1,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 2, 5, 32'd77,    1, 0, 1, 1, 0);
        tbl[8]  = v(1, 1, 1, 0, 0, 0, 32'd100,     1, 1, 0,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 1, 0, 32'd100,   1, 1, 0, 1, 0);
        tbl[9]  = v(1, 1, 0, 0, 9, 1, 32'd0,       1, 0, 5,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 0, 9, 32'd0,     1, 0, 5, 1, 0);
        tbl[10] = v(1, 1, 1, 5, 5, 0, 32'd100,     1, 1, 0,  0, 0,  32'h0,        2'b00, 0,  1, 0, 1, 1, 5, 32'd100,   1, 1, 0, 1, 0);
        tbl[11] = v(1, 1, 5, 2, 8, 1, 32'd55,      1, 0, 3,  0, 0,  32'h0,        2'b01, 0,  1, 0, 0, 0, 0, 32'h0,     0, 0, 0, 1, 1);
        tbl[12] = v(1, 0, 4, 0, 6, 0, 32'd99,      1, 1, 0,  0, 0,  32'h0,        2'b00, 0,  1, 0, 0, 4, 6, 32'd99,    0, 0, 0, 1, 1);
        tbl[13] = v(1, 1, 7, 0, 3, 0, 32'h0,       1, 0, 2,  1, 7,  32'hCAFE,     2'b00, 0,  1, 0, 1, 7, 3, 32'hCAFE,  1, 0, 2, 1, 1);
        tbl[14] = v(1, 1, 0, 0, 3, 0, 32'h11,      1, 0, 2,  1, 0,  32'hBEEF,     2'b00, 0,  1, 0, 1, 0, 3, 32'h11,    1, 0, 2, 1, 1);
        tbl[15] = v(1, 1, 7, 0, 3, 0, 32'h22,      1, 0, 2,  0, 7,  32'hCAFE,     2'b00, 0,  1, 0, 1, 7, 3, 32'h22,    1, 0, 2, 1, 1);

        rstn = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        set_misc(1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
        tick();

        for (int i = 0; i < 16; i++) apply(i, tbl[i]);

        // Freeze: lw in ID/EX, hazarding add in ID, memstall held for 3 cycles
        drive_lw();
        set_misc(1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
        tick();
        drive_add_rs5();
        set_misc(1'b1, 5'd5, 32'h9999, 2'b00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("frz stall", {31'd0, stall}, 32'd0);
            tick();
            chk("frz valid",    {31'd0, IDEXvalid},    32'd1);
            chk("frz rd",       {27'd0, IDEXrd},       32'd5);
            chk("frz rsdata",   IDEXrsdata,            32'd100);
            chk("frz rtdata",   IDEXrtdata,            32'd200);
            chk("frz imm",      IDEXimm,               32'h10);
            chk("frz memread",  {31'd0, IDEXmemread},  32'd1);
            chk("frz memtoreg", {31'd0, IDEXmemtoreg}, 32'd1);
            chk("frz alusrc",   {31'd0, IDEXalusrc},   32'd1);
            chk("frz stallcnt", {28'd0, stallcnt},     32'd1);
            chk("frz flushcnt", {28'd0, flushcnt},     32'd1);
        end
        set_misc(1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
        #1;
        chk("unfrz stall", {31'd0, stall}, 32'd1);
        tick();
        chk("unfrz bubble valid", {31'd0, IDEXvalid},   32'd0);
        chk("unfrz bubble mr",    {31'd0, IDEXmemread}, 32'd0);
        chk("unfrz stallcnt",     {28'd0, stallcnt},    32'd2);
        #1;
        chk("re-present stall", {31'd0, stall}, 32'd0);
        tick();
        chk("re-present valid",  {31'd0, IDEXvalid}, 32'd1);
        chk("re-present rd",     {27'd0, IDEXrd},    32'd8);
        chk("re-present rsdata", IDEXrsdata,         32'd55);

        // rt write-through
        set_id(1'b1, 5'd3, 5'd9, 5'd4, 1'b1, 32'd33, 32'd1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1);
        set_misc(1'b1, 5'd9, 32'hF00D, 2'b00, 1'b0);
        tick();
        chk("wt rtdata", IDEXrtdata, 32'hF00D);
        chk("wt rsdata", IDEXrsdata, 32'd33);
        chk("wt rt",     {27'd0, IDEXrt}, 32'd9);

        // Reset asserted while a stall is active
        set_misc(1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
        drive_lw();
        tick();
        drive_add_rs5();
        #1;
        chk("rststall stall before", {31'd0, stall}, 32'd1);
        rstn = 1'b0;
        tick();
        chk("rststall valid",    {31'd0, IDEXvalid},   32'd0);
        chk("rststall memread",  {31'd0, IDEXmemread}, 32'd0);
        chk("rststall stall",    {31'd0, stall},       32'd0);
        chk("rststall stallcnt", {28'd0, stallcnt},    32'd0);
        chk("rststall flushcnt", {28'd0, flushcnt},    32'd0);
        rstn = 1'b1;

        // Stall counter saturation; odd iterations hazard through rt only
        for (int i = 0; i < 17; i++) begin
            drive_lw();
            tick();
            if (i % 2 == 0)
                set_id(1'b1, 5'd5, 5'd0, 5'd8, 1'b0, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
            else
                set_id(1'b1, 5'd0, 5'd5, 5'd8, 1'b1, 32'd1, 32'd2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3);
            #1;
            chk($sformatf("sat stall %0d", i), {31'd0, stall}, 32'd1);
            tick();
            chk($sformatf("sat stallcnt %0d", i), {28'd0, stallcnt},
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end

        // Flush counter saturation with a hazard present; stall counter must not move
        drive_lw();
        tick();
        drive_add_rs5();
        set_misc(1'b0, 5'd0, 32'h0, 2'b10, 1'b0);
        for (int i = 0; i < 17; i++) begin
            #1;
            chk($sformatf("fsat stall %0d", i), {31'd0, stall}, 32'd0);
            tick();
            chk($sformatf("fsat valid %0d", i),    {31'd0, IDEXvalid}, 32'd0);
            chk($sformatf("fsat flushcnt %0d", i), {28'd0, flushcnt},
                (i + 1 > 15) ? 32'd15 : 32'(i + 1));
            chk($sformatf("fsat stallcnt %0d", i), {28'd0, stallcnt}, 32'd15);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
